// File: rtl/cnt_lfsr_tk1.sv
// rtl/cnt_lfsr_tk1.sv - Romulus block-counter LFSR and domain byte packed as SKINNY TK1
// Optional feature macro: CNT_WRAP_FLAG_EN (adds the registered wrap pulse output).
module cnt_lfsr_tk1 #(
  parameter int               CNT_W    = 56,
  parameter logic [CNT_W-1:0] INIT_VAL = 56'h1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             init,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             inc2,
  input  logic             dom_we,
  input  logic [7:0]       dom_in,
  output logic             busy,
  output logic             valid,
  output logic [127:0]     tk1,
  output logic [CNT_W-1:0] cnt
`ifdef CNT_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  // Feedback taps for x^56 + x^7 + x^4 + x^2 + 1 (the x^56 term is the shifted-out bit).
  localparam logic [CNT_W-1:0] POLY = CNT_W'('h95);
  // Value reached after a full period; a step landing here marks wrap-around.
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP2 = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       dom_q;
  logic [CNT_W-1:0] cnt_step;
`ifdef CNT_WRAP_FLAG_EN
  logic             wrap_q;
`endif

  // Galois LFSR step; the all-zero value maps to itself (lock-up, only reachable by load).
  function automatic logic [CNT_W-1:0] lfsr_step(input logic [CNT_W-1:0] x);
    lfsr_step = {x[CNT_W-2:0], 1'b0} ^ (x[CNT_W-1] ? POLY : '0);
  endfunction

  // Next counter value for any step issued this cycle.
  always_comb begin
    cnt_step = lfsr_step(cnt_q);
  end

  // Command FSM: the second half of a double step owns the edge, otherwise init > load > inc2 > inc.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      cnt_q  <= '0;
      dom_q  <= 8'h00;
      busy   <= 1'b0;
      valid  <= 1'b0;
`ifdef CNT_WRAP_FLAG_EN
      wrap_q <= 1'b0;
`endif
    end else begin
      // The domain byte is written regardless of counter activity.
      if (dom_we) begin
        dom_q <= dom_in;
      end
`ifdef CNT_WRAP_FLAG_EN
      wrap_q <= 1'b0;
`endif
      case (state)
        ST_STEP2: begin
          cnt_q  <= cnt_step;
          state  <= ST_RUN;
          busy   <= 1'b0;
          valid  <= 1'b1;
`ifdef CNT_WRAP_FLAG_EN
          wrap_q <= (cnt_step == ONE);
`endif
        end
        default: begin
          if (init) begin
            cnt_q <= INIT_VAL;
            state <= ST_RUN;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else if (load) begin
            cnt_q <= load_val;
            state <= ST_RUN;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else if (inc2 && (state == ST_RUN)) begin
            cnt_q  <= cnt_step;
            state  <= ST_STEP2;
            busy   <= 1'b1;
            valid  <= 1'b0;
`ifdef CNT_WRAP_FLAG_EN
            wrap_q <= (cnt_step == ONE);
`endif
          end else if (inc && (state == ST_RUN)) begin
            cnt_q  <= cnt_step;
`ifdef CNT_WRAP_FLAG_EN
            wrap_q <= (cnt_step == ONE);
`endif
          end
        end
      endcase
    end
  end

  // TK1 is built only from registered state: counter bytes little-endian from the top, then domain.
  always_comb begin
    tk1           = '0;
    tk1[127:120]  = cnt_q[7:0];
    tk1[119:112]  = cnt_q[15:8];
    tk1[111:104]  = cnt_q[23:16];
    tk1[103:96]   = cnt_q[31:24];
    tk1[95:88]    = cnt_q[39:32];
    tk1[87:80]    = cnt_q[47:40];
    tk1[79:72]    = cnt_q[55:48];
    tk1[71:64]    = dom_q;
  end

  assign cnt  = cnt_q;
`ifdef CNT_WRAP_FLAG_EN
  assign wrap = wrap_q;
`endif

endmodule

// File: doc/cnt_lfsr_tk1.md
Name: cnt_lfsr_tk1

Overview:
- Romulus block-counter stage, SKINNY-128-384+ datapath.
- Holds the 56-bit block-counter LFSR and the 8-bit domain-separation byte.
- Presents both as the 128-bit TK1 word consumed directly by the counter tweakey-expansion/permutation stage.
- Controller issues init, load, single-step and double-step commands. The block reports busy/valid so the controller never samples TK1 mid-update.

Parameters:
- CNT_W, 56, counter width in bits; fixed at 56 for Romulus (7 bytes).
- INIT_VAL, 56'h1, value written on init command.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  synchronous active-low reset
- init  input  1  load INIT_VAL into counter
- load  input  1  load load_val into counter
- load_val  input  56  value for load
- inc  input  1  advance LFSR one step
- inc2  input  1  advance LFSR two steps (two cycles)
- dom_we  input  1  write domain byte
- dom_in  input  8  domain-separation byte
- busy  output  1  multi-cycle step in progress; commands ignored
- valid  output  1  counter holds a defined value since init/load
- tk1  output  128  TK1 word
- cnt  output  56  raw counter value

Behaviour:
- Reset: rstn=0 at a clk edge sets:
  - counter to 0, domain to 8'h00
  - busy=0, valid=0
  - state IDLE
  - Reset mid-STEP2 aborts the second step.
- LFSR step:
  - x' = {x[54:0],1'b0} ^ (x[55] ? 56'h95 : 0); polynomial x^56+x^7+x^4+x^2+1.
  - x=0 is a lock-up state and stays 0; it is reachable only via load.
- TK1 packing (little-endian counter bytes, MSB byte first in word):
  - tk1[127:120]=x[7:0], tk1[119:112]=x[15:8], tk1[111:104]=x[23:16], tk1[103:96]=x[31:24]
  - tk1[95:88]=x[39:32], tk1[87:80]=x[47:40], tk1[79:72]=x[55:48]
  - tk1[71:64]=domain, tk1[63:0]=0
  - tk1 and cnt are purely registered: no combinational path from inputs.
- FSM states:
  - IDLE: valid=0.
  - RUN: valid=1.
  - STEP2: busy=1, valid=0.
- Command priority, sampled at a clk edge when busy=0: init > load > inc2 > inc. Lower-priority commands in the same cycle are dropped.
  - init: counter<=INIT_VAL, state<=RUN. Visible next cycle.
  - load: counter<=load_val, state<=RUN. Visible next cycle.
  - inc in RUN: one step. valid stays 1. Latency 1 cycle.
  - inc2 in RUN: first step this edge, state<=STEP2. Second step at the next edge, state<=RUN.
  - Result is visible 2 cycles after the command. busy=1 and valid=0 during the intermediate cycle.
  - inc/inc2 in IDLE: ignored, counter unchanged.
  - Any command while busy=1: ignored, including init and load.
- dom_we: independent of the FSM. Domain updates at the next edge in any state, including STEP2. Accepted in the same cycle as any counter command.

Optional Feature:
- Macro: CNT_WRAP_FLAG_EN.
- When defined:
  - Adds output port wrap (1 bit).
  - wrap is a registered one-cycle pulse, asserted in the cycle after any step whose result equals 56'h1, i.e. the counter has completed its period of 2^56-1.
  - With inc2, the pulse fires for whichever of the two steps produced 1.
  - Cleared by reset.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- rstn=0 for 2 cycles, then rstn=1 with no commands -> tk1=0, cnt=0, valid=0, busy=0; inc pulse -> no change.
- init, dom_we with dom_in=8'h04 in the same cycle -> next cycle cnt=56'h1, tk1=128'h01000000_00000004_00000000_00000000, valid=1.
- From cnt=1: 8 single inc pulses -> cnt=56'h100, tk1[119:112]=8'h01, all other counter bytes 0.
- load 56'h80000000000000, then inc -> cnt=56'h95, tk1[127:120]=8'h95; inc2 -> busy=1 one cycle, then cnt=56'h254; inc asserted during busy is ignored.
- load 56'h8000000000004A, inc -> cnt=56'h1; with CNT_WRAP_FLAG_EN, wrap=1 for exactly one cycle.
- inc2 issued, rstn=0 on the following edge -> cnt=0, busy=0, valid=0; init plus inc in the same cycle -> cnt=1 (init wins, inc dropped).
